// File: rtl/adc_runup_ctl.sv
// Multi-slope run-up/run-down sequencer for the integrating ADC front end.
// Drives the reference-current mux and comparator latch, and latches per-conversion counts.
module adc_runup_ctl #(
    parameter int unsigned RUNUP_PERIOD = 20,
    parameter logic [23:0] RUNDOWN_MAX  = 24'd100000,
    parameter logic [3:0]  REFMUX_NONE  = 4'b0000,
    parameter logic [3:0]  REFMUX_POS   = 4'b0001,
    parameter logic [3:0]  REFMUX_NEG   = 4'b0010,
    parameter logic [3:0]  REFMUX_RESET = 4'b1100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        adc_measure_trig_i,
    input  logic [31:0] p_clk_count_aperture_i,
    input  logic [23:0] p_clk_count_reset_i,
    input  logic        cmpr_val_i,
    output logic        adc_measure_valid_o,
    output logic [3:0]  adc_refmux_o,
    output logic        adc_cmpr_latch_o,
    output logic [31:0] clk_count_mux_sig_o,
    output logic [23:0] stat_count_refmux_pos_up_o,
    output logic [23:0] stat_count_refmux_neg_up_o,
    output logic [23:0] clk_count_rundown_o,
    output logic        rundown_timeout_o,
    output logic [5:0]  monitor_o
);

    localparam int unsigned   PW         = (RUNUP_PERIOD > 1) ? $clog2(RUNUP_PERIOD) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(RUNUP_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_SIG     = 3'd2,
        S_RUNDOWN = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [3:0]    refmux, refmux_n;
    logic          latch, latch_n, valid, valid_n, strobe, strobe_n;
    logic          sync1, sync2, cmpr_s;
    logic [PW-1:0] phase, phase_n;
    logic [23:0]   rcnt, rcnt_n, pos_cnt, pos_n, neg_cnt, neg_n, rd_cnt, rd_n;
    logic [31:0]   sig_cnt, sig_n, sig_next;
    logic          rd_dir, rd_dir_n;
    logic [31:0]   out_sig, out_sig_n;
    logic [23:0]   out_pos, out_pos_n, out_neg, out_neg_n, out_rd, out_rd_n;
    logic          timeout, timeout_n;
    logic [23:0]   rlimit, rd_next;
    logic          start_phase;

    function automatic logic [23:0] sat_inc(input logic [23:0] v);
        return (v == '1) ? v : v + 24'd1;
    endfunction

    assign cmpr_s   = sync2;
    assign rlimit   = (p_clk_count_reset_i == '0) ? 24'd1 : p_clk_count_reset_i;
    assign rd_next  = sat_inc(rd_cnt);
    assign sig_next = sig_cnt + 32'd1;

    always_comb begin
        state_n     = state;
        refmux_n    = refmux;
        latch_n     = latch;
        valid_n     = valid;
        strobe_n    = 1'b0;
        phase_n     = phase;
        rcnt_n      = rcnt;
        sig_n       = sig_cnt;
        pos_n       = pos_cnt;
        neg_n       = neg_cnt;
        rd_n        = rd_cnt;
        rd_dir_n    = rd_dir;
        out_sig_n   = out_sig;
        out_pos_n   = out_pos;
        out_neg_n   = out_neg;
        out_rd_n    = out_rd;
        timeout_n   = timeout;
        start_phase = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (adc_measure_trig_i) begin
                    state_n  = S_RESET;
                    refmux_n = REFMUX_RESET;
                    latch_n  = 1'b0;
                    valid_n  = 1'b0;
                    phase_n  = '0;
                    rcnt_n   = '0;
                    sig_n    = '0;
                    pos_n    = '0;
                    neg_n    = '0;
                    rd_n     = '0;
                end
            end
            S_RESET: begin
                if (rcnt == rlimit - 24'd1) begin
                    state_n     = S_SIG;
                    phase_n     = '0;
                    start_phase = 1'b1;
                end else begin
                    rcnt_n = rcnt + 24'd1;
                end
            end
            S_SIG: begin
                sig_n = sig_next;
                if (phase == PHASE_LAST) begin
                    // Aperture is only checked at a phase wrap, so it rounds up to whole phases.
                    if (sig_next >= p_clk_count_aperture_i) begin
                        state_n  = S_RUNDOWN;
                        refmux_n = cmpr_s ? REFMUX_NEG : REFMUX_POS;
                        rd_dir_n = cmpr_s;
                    end else begin
                        phase_n     = '0;
                        start_phase = 1'b1;
                    end
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            S_RUNDOWN: begin
                rd_n = rd_next;
                if ((cmpr_s != rd_dir) || (rd_next >= RUNDOWN_MAX)) begin
                    state_n   = S_DONE;
                    refmux_n  = REFMUX_NONE;
                    latch_n   = 1'b1;
                    valid_n   = 1'b1;
                    out_sig_n = sig_cnt;
                    out_pos_n = pos_cnt;
                    out_neg_n = neg_cnt;
                    out_rd_n  = rd_next;
                    timeout_n = (cmpr_s == rd_dir);
                end
            end
            default: begin
                state_n  = S_IDLE;
                refmux_n = REFMUX_NONE;
                latch_n  = 1'b1;
                valid_n  = 1'b1;
            end
        endcase

        if (start_phase) begin
            strobe_n = 1'b1;
            if (cmpr_s) begin
                refmux_n = REFMUX_NEG;
                neg_n    = sat_inc(neg_cnt);
            end else begin
                refmux_n = REFMUX_POS;
                pos_n    = sat_inc(pos_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            refmux  <= REFMUX_NONE;
            latch   <= 1'b1;
            valid   <= 1'b1;
            strobe  <= 1'b0;
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            phase   <= '0;
            rcnt    <= '0;
            sig_cnt <= '0;
            pos_cnt <= '0;
            neg_cnt <= '0;
            rd_cnt  <= '0;
            rd_dir  <= 1'b0;
            out_sig <= '0;
            out_pos <= '0;
            out_neg <= '0;
            out_rd  <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            refmux  <= refmux_n;
            latch   <= latch_n;
            valid   <= valid_n;
            strobe  <= strobe_n;
            sync1   <= cmpr_val_i;
            sync2   <= sync1;
            phase   <= phase_n;
            rcnt    <= rcnt_n;
            sig_cnt <= sig_n;
            pos_cnt <= pos_n;
            neg_cnt <= neg_n;
            rd_cnt  <= rd_n;
            rd_dir  <= rd_dir_n;
            out_sig <= out_sig_n;
            out_pos <= out_pos_n;
            out_neg <= out_neg_n;
            out_rd  <= out_rd_n;
            timeout <= timeout_n;
        end
    end

    assign adc_measure_valid_o        = valid;
    assign adc_refmux_o               = refmux;
    assign adc_cmpr_latch_o           = latch;
    assign clk_count_mux_sig_o        = out_sig;
    assign stat_count_refmux_pos_up_o = out_pos;
    assign stat_count_refmux_neg_up_o = out_neg;
    assign clk_count_rundown_o        = out_rd;
    assign rundown_timeout_o          = timeout;
    assign monitor_o                  = {valid, strobe, sync2, state};

endmodule

// File: tb/tb_adc_runup_ctl.sv
// Self-checking bench for adc_runup_ctl: closed-loop integrator stimulus, results
// predicted from the recorded comparator history using the conversion timing rules.
module tb_adc_runup_ctl;

    localparam int P     = 20;
    localparam int RDMAX = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trig = 1'b0;
    logic        cmpr = 1'b0;
    logic [31:0] aperture = '0;
    logic [23:0] rst_cnt = '0;
    logic        valid, latch, o_to;
    logic [3:0]  refmux;
    logic [31:0] o_sig;
    logic [23:0] o_pos, o_neg, o_rd;
    logic [5:0]  mon;

    adc_runup_ctl #(.RUNUP_PERIOD(P), .RUNDOWN_MAX(24'd50)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .adc_measure_trig_i         (trig),
        .p_clk_count_aperture_i     (aperture),
        .p_clk_count_reset_i        (rst_cnt),
        .cmpr_val_i                 (cmpr),
        .adc_measure_valid_o        (valid),
        .adc_refmux_o               (refmux),
        .adc_cmpr_latch_o           (latch),
        .clk_count_mux_sig_o        (o_sig),
        .stat_count_refmux_pos_up_o (o_pos),
        .stat_count_refmux_neg_up_o (o_neg),
        .clk_count_rundown_o        (o_rd),
        .rundown_timeout_o          (o_to),
        .monitor_o                  (mon)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit hist[$];
    int v = 0;
    int sig_in = 0;
    bit force_hi = 1'b0;
    int rd_neg = 0;
    int exp_pos, exp_neg, exp_sig, exp_rd, exp_to, exp_done;

    // hist[k] = comparator level sampled at posedge number k
    always @(posedge clk) begin
        hist.push_back(cmpr);
        cyc++;
    end

    // Integrator: references pull at 16/clock, signal adds sig_in while a reference is active
    always @(negedge clk) begin
        if (refmux == 4'b1100) v = 0;
        else if (refmux == 4'b0001) v = v + 16 + sig_in;
        else if (refmux == 4'b0010) v = v - 16 + sig_in;
        cmpr = force_hi ? 1'b1 : (v > 0);
    end

    task automatic model(input int e0, input int a, input int r);
        int rr, aa, nph, x, d, idx;
        bit dir;
        rr = (r == 0) ? 1 : r;
        aa = (a == 0) ? 1 : a;
        nph = (aa + P - 1) / P;
        exp_pos = 0;
        exp_neg = 0;
        for (int j = 0; j < nph; j++) begin
            if (hist[e0 + rr + j * P - 2]) exp_neg++;
            else exp_pos++;
        end
        exp_sig = nph * P;
        x = e0 + rr + nph * P;
        dir = hist[x - 2];
        exp_to = 0;
        d = 0;
        for (int k = 1; k <= RDMAX; k++) begin
            d = k;
            idx = x + k - 2;
            if (idx >= hist.size()) break;
            if (hist[idx] != dir) break;
            if (k >= RDMAX) exp_to = 1;
        end
        exp_rd = d;
        exp_done = x + d;
    endtask

    task automatic start_conv(input int a, input int r, output int e0);
        aperture = a;
        rst_cnt = r;
        @(negedge clk);
        trig = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc - 1;
    endtask

    task automatic wait_done(input int busy_at, output int done_edge, output bit ok);
        ok = 1'b0;
        done_edge = -1;
        rd_neg = 0;
        for (int i = 1; i <= 4000; i++) begin
            @(negedge clk);
            if (valid) begin
                ok = 1'b1;
                done_edge = cyc - 1;
                trig = 1'b0;
                break;
            end
            trig = (i == busy_at);
            if (mon[2:0] == 3'd3 && refmux == 4'b0010) rd_neg++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_done: valid never rose within 4000 clocks");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL reset_valid: got %0b want 1", valid); end
        checks++; if (refmux !== 4'b0000) begin failures++; $display("FAIL reset_refmux: got %b want 0000", refmux); end
        checks++; if (latch !== 1'b1) begin failures++; $display("FAIL reset_latch: got %0b want 1", latch); end
        checks++; if ({o_sig, o_pos, o_neg, o_rd, o_to} !== '0) begin failures++; $display("FAIL reset_counts: sig=%0d pos=%0d neg=%0d rd=%0d to=%0b want all 0", o_sig, o_pos, o_neg, o_rd, o_to); end
        checks++; if (mon[2:0] !== 3'd0 || mon[5] !== 1'b1) begin failures++; $display("FAIL reset_monitor: got %b want state 0 valid 1", mon); end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_normal();
        int e0, de;
        bit ok;
        force_hi = 1'b0;
        sig_in = 2;
        start_conv(100, 10, e0);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL normal_valid_fall: got %0b want 0", valid); end
        checks++; if (refmux !== 4'b1100) begin failures++; $display("FAIL normal_refmux_reset: got %b want 1100", refmux); end
        checks++; if (mon[2:0] !== 3'd1 || latch !== 1'b0) begin failures++; $display("FAIL normal_enter_reset: state=%0d latch=%0b want 1/0", mon[2:0], latch); end
        wait_done(0, de, ok);
        model(e0, 100, 10);
        checks++; if (o_sig !== 32'd100) begin failures++; $display("FAIL normal_sig: got %0d want 100", o_sig); end
        checks++; if (int'(o_pos) + int'(o_neg) != 5) begin failures++; $display("FAIL normal_phases: got %0d want 5", o_pos + o_neg); end
        checks++; if (o_pos !== 24'(exp_pos) || o_neg !== 24'(exp_neg)) begin failures++; $display("FAIL normal_split: got pos=%0d neg=%0d want %0d/%0d", o_pos, o_neg, exp_pos, exp_neg); end
        checks++; if (o_rd !== 24'(exp_rd) || o_to !== 1'b0) begin failures++; $display("FAIL normal_rundown: got rd=%0d to=%0b want %0d/0", o_rd, o_to, exp_rd); end
        checks++; if (de != exp_done || latch !== 1'b1 || refmux !== 4'b0000) begin failures++; $display("FAIL normal_done: got edge=%0d latch=%0b mux=%b want edge=%0d 1 0000", de, latch, refmux, exp_done); end
    endtask

    task automatic test_aperture();
        int e0, de;
        bit ok;
        sig_in = -1;
        start_conv(101, 10, e0);
        wait_done(0, de, ok);
        model(e0, 101, 10);
        checks++; if (o_sig !== 32'd120 || int'(o_pos) + int'(o_neg) != 6) begin failures++; $display("FAIL aperture_101: got sig=%0d phases=%0d want 120/6", o_sig, o_pos + o_neg); end
        checks++; if (o_pos !== 24'(exp_pos) || o_rd !== 24'(exp_rd) || de != exp_done) begin failures++; $display("FAIL aperture_101_model: got pos=%0d rd=%0d edge=%0d want %0d/%0d/%0d", o_pos, o_rd, de, exp_pos, exp_rd, exp_done); end
        start_conv(0, 0, e0);
        wait_done(0, de, ok);
        model(e0, 0, 0);
        checks++; if (o_sig !== 32'd20 || int'(o_pos) + int'(o_neg) != 1) begin failures++; $display("FAIL aperture_0: got sig=%0d phases=%0d want 20/1", o_sig, o_pos + o_neg); end
        checks++; if (de != exp_done || o_rd !== 24'(exp_rd)) begin failures++; $display("FAIL aperture_0_timing: got edge=%0d rd=%0d want %0d/%0d", de, o_rd, exp_done, exp_rd); end
    endtask

    task automatic test_random();
        int e0, de, a, r;
        bit ok;
        for (int n = 0; n < 6; n++) begin
            a = int'($urandom_range(130));
            r = int'($urandom_range(12));
            sig_in = int'($urandom_range(6)) - 3;
            start_conv(a, r, e0);
            wait_done(0, de, ok);
            model(e0, a, r);
            checks++;
            if (o_sig !== 32'(exp_sig) || o_pos !== 24'(exp_pos) || o_neg !== 24'(exp_neg) ||
                o_rd !== 24'(exp_rd) || o_to !== exp_to[0] || de != exp_done) begin
                failures++;
                $display("FAIL random_%0d (a=%0d r=%0d): got sig=%0d pos=%0d neg=%0d rd=%0d to=%0b edge=%0d want %0d/%0d/%0d/%0d/%0d/%0d",
                         n, a, r, o_sig, o_pos, o_neg, o_rd, o_to, de, exp_sig, exp_pos, exp_neg, exp_rd, exp_to, exp_done);
            end
        end
    endtask

    task automatic test_timeout();
        int e0, de;
        bit ok;
        force_hi = 1'b1;
        start_conv(20, 3, e0);
        wait_done(0, de, ok);
        model(e0, 20, 3);
        checks++; if (o_rd !== 24'd50 || o_to !== 1'b1) begin failures++; $display("FAIL timeout_rundown: got rd=%0d to=%0b want 50/1", o_rd, o_to); end
        checks++; if (rd_neg != 50) begin failures++; $display("FAIL timeout_neg_clocks: got %0d want 50", rd_neg); end
        checks++; if (o_neg !== 24'd1 || o_pos !== 24'd0 || valid !== 1'b1 || de != exp_done) begin failures++; $display("FAIL timeout_done: got neg=%0d pos=%0d valid=%0b edge=%0d want 1/0/1/%0d", o_neg, o_pos, valid, de, exp_done); end
        force_hi = 1'b0;
    endtask

    task automatic test_busy_trig();
        int e0, de;
        bit ok;
        sig_in = 1;
        start_conv(60, 5, e0);
        wait_done(30, de, ok);
        model(e0, 60, 5);
        checks++;
        if (de != exp_done || o_sig !== 32'd60 || o_pos !== 24'(exp_pos) || o_neg !== 24'(exp_neg) || o_rd !== 24'(exp_rd)) begin
            failures++;
            $display("FAIL busy_trig: got edge=%0d sig=%0d pos=%0d neg=%0d rd=%0d want %0d/60/%0d/%0d/%0d",
                     de, o_sig, o_pos, o_neg, o_rd, exp_done, exp_pos, exp_neg, exp_rd);
        end
    endtask

    task automatic test_back_to_back();
        int e0, de, e0b, de2;
        bit ok, hold_bad, done2;
        logic [31:0] s1;
        logic [23:0] p1, n1, r1;
        sig_in = -2;
        start_conv(40, 3, e0);
        wait_done(0, de, ok);
        model(e0, 40, 3);
        checks++; if (o_sig !== 32'd40 || o_pos !== 24'(exp_pos) || o_rd !== 24'(exp_rd)) begin failures++; $display("FAIL b2b_first: got sig=%0d pos=%0d rd=%0d want 40/%0d/%0d", o_sig, o_pos, o_rd, exp_pos, exp_rd); end
        s1 = o_sig; p1 = o_pos; n1 = o_neg; r1 = o_rd;
        trig = 1'b1;
        @(posedge clk);
        #1;
        e0b = cyc - 1;
        checks++; if (mon[2:0] !== 3'd1 || valid !== 1'b0) begin failures++; $display("FAIL b2b_restart: got state=%0d valid=%0b want 1/0", mon[2:0], valid); end
        hold_bad = 1'b0;
        done2 = 1'b0;
        de2 = -1;
        for (int i = 1; i <= 4000; i++) begin
            @(negedge clk);
            if (i == 3) trig = 1'b0;
            if (valid) begin
                done2 = 1'b1;
                de2 = cyc - 1;
                break;
            end
            if (o_sig !== s1 || o_pos !== p1 || o_neg !== n1 || o_rd !== r1) hold_bad = 1'b1;
        end
        trig = 1'b0;
        checks++; if (hold_bad || !done2) begin failures++; $display("FAIL b2b_hold: got hold_bad=%0b done=%0b want 0/1", hold_bad, done2); end
        model(e0b, 40, 3);
        checks++; if (de2 != exp_done || o_pos !== 24'(exp_pos) || o_neg !== 24'(exp_neg) || o_rd !== 24'(exp_rd)) begin failures++; $display("FAIL b2b_second: got edge=%0d pos=%0d neg=%0d rd=%0d want %0d/%0d/%0d/%0d", de2, o_pos, o_neg, o_rd, exp_done, exp_pos, exp_neg, exp_rd); end
    endtask

    task automatic test_reset_mid();
        int e0, de;
        bit ok, seen;
        force_hi = 1'b1;
        start_conv(20, 2, e0);
        @(negedge clk);
        trig = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (mon[2:0] == 3'd3) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!seen) begin failures++; $display("FAIL reset_mid_reach_rundown: got state=%0d want 3", mon[2:0]); end
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (mon[2:0] !== 3'd0 || refmux !== 4'b0000 || latch !== 1'b1 || valid !== 1'b1) begin failures++; $display("FAIL reset_mid_state: got state=%0d mux=%b latch=%0b valid=%0b want 0/0000/1/1", mon[2:0], refmux, latch, valid); end
        checks++; if ({o_sig, o_pos, o_neg, o_rd, o_to} !== '0) begin failures++; $display("FAIL reset_mid_counts: got sig=%0d pos=%0d neg=%0d rd=%0d to=%0b want 0", o_sig, o_pos, o_neg, o_rd, o_to); end
        @(negedge clk);
        reset = 1'b0;
        force_hi = 1'b0;
        sig_in = 3;
        repeat (4) @(negedge clk);
        start_conv(60, 4, e0);
        wait_done(0, de, ok);
        model(e0, 60, 4);
        checks++; if (de != exp_done || o_sig !== 32'd60 || o_pos !== 24'(exp_pos) || o_neg !== 24'(exp_neg) || o_rd !== 24'(exp_rd) || o_to !== exp_to[0]) begin failures++; $display("FAIL reset_mid_after: got edge=%0d sig=%0d pos=%0d neg=%0d rd=%0d want %0d/60/%0d/%0d/%0d", de, o_sig, o_pos, o_neg, o_rd, exp_done, exp_pos, exp_neg, exp_rd); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_aperture();
        test_random();
        test_timeout();
        test_busy_trig();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
